fir_batch_sequencer: RTL and testbench

//  Front-end controller for the parallel FIR shift_register. Packs a serial sample stream into PARALLELISM-wide batches.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_batch_sequencer_valid_delay_line.sv | 36 +++
 rtl/fir_batch_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fir_batch_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, counter widths and state encoding for the FIR batch front-end.
// Everything here is derived from the tap count, sample width and batch size.
package fir_pkg;

    localparam int N             = 21;
    localparam int NB            = 18;
    localparam int P             = 8;
    localparam int MEM_LEN       = N + P - 1;
    localparam int PRIME_BATCHES = (MEM_LEN + P - 1) / P;
    localparam int DRAIN_BATCHES = (N - 1 + P - 1) / P;

    localparam int LANE_W  = (P > 1) ? $clog2(P) : 1;
    localparam int BATCH_W = $clog2(PRIME_BATCHES + 1);
    localparam int DRAIN_W = $clog2(DRAIN_BATCHES + 1);

    typedef enum logic [2:0] {
        FILL,
        RUN,
        PAD,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/fir_batch_sequencer_valid_delay_line.sv
// Clock-enabled shift pipe that carries the per-batch "real output" tag
// alongside the FIR arithmetic latency; cleared synchronously by reset.
module valid_delay_line #(
    parameter int LATENCY = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_valid,
    output logic o_valid
);

    logic [LATENCY-1:0] pipe_q;
    logic [LATENCY-1:0] pipe_d;

    always_comb begin
        pipe_d = pipe_q;
        if (i_enable) begin
            pipe_d[0] = i_valid;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign o_valid = pipe_q[LATENCY-1];

endmodule

// File: rtl/fir_batch_sequencer.sv
// Packs a serial sample stream into P-wide batches for the parallel FIR shift
// register, tracks window priming and sequences the end-of-stream flush/drain.
module fir_batch_sequencer
    import fir_pkg::*;
#(
    parameter int FIR_LATENCY = 2
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_enable,
    input  logic            i_sample_valid,
    input  logic [NB-1:0]   i_sample,
    output logic            o_sample_ready,
    input  logic            i_flush,
    output logic            o_sr_valid,
    output logic [P*NB-1:0] o_sr_data,
    output logic            o_primed,
    output logic            o_fir_valid,
    output logic            o_flush_done
);

    seq_state_t             state_q, state_d;
    logic [LANE_W-1:0]      lane_cnt_q, lane_cnt_d;
    logic [BATCH_W-1:0]     batch_cnt_q, batch_cnt_d;
    logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic [P-1:0][NB-1:0]   build_q, build_d;
    logic [P*NB-1:0]        sr_data_q, sr_data_d;
    logic                   sr_valid_q, sr_valid_d;
    logic                   tag_q, tag_d;
    logic                   flush_primed_q, flush_primed_d;
    logic                   flush_done_q, flush_done_d;

    logic ready;
    logic accept;
    logic last_lane;

    assign ready     = i_enable && !i_reset && (state_q == FILL || state_q == RUN);
    assign accept    = ready && i_sample_valid;
    assign last_lane = (lane_cnt_q == LANE_W'(P - 1));

    always_comb begin
        state_d        = state_q;
        lane_cnt_d     = lane_cnt_q;
        batch_cnt_d    = batch_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        build_d        = build_q;
        sr_data_d      = sr_data_q;
        sr_valid_d     = sr_valid_q;
        tag_d          = tag_q;
        flush_primed_d = flush_primed_q;
        flush_done_d   = flush_done_q;

        // With the clock enable low nothing moves, so a pending strobe is held.
        if (i_enable) begin
            sr_valid_d   = 1'b0;
            flush_done_d = 1'b0;
            case (state_q)
                FILL, RUN: begin
                    if (accept) begin
                        build_d[lane_cnt_q] = i_sample;
                        if (last_lane) begin
                            lane_cnt_d = '0;
                            sr_data_d  = build_d;
                            sr_valid_d = 1'b1;
                            tag_d      = (batch_cnt_q >= BATCH_W'(PRIME_BATCHES - 1));
                            if (batch_cnt_q != BATCH_W'(PRIME_BATCHES)) begin
                                batch_cnt_d = batch_cnt_q + BATCH_W'(1);
                            end
                            if (batch_cnt_q == BATCH_W'(PRIME_BATCHES - 1)) begin
                                state_d = RUN;
                            end
                        end else begin
                            lane_cnt_d = lane_cnt_q + LANE_W'(1);
                        end
                    end
                    // A sample arriving with the flush is packed first; a batch it
                    // completes has already issued above, leaving nothing to pad.
                    if (i_flush) begin
                        flush_primed_d = (batch_cnt_d == BATCH_W'(PRIME_BATCHES));
                        drain_cnt_d    = '0;
                        state_d        = (lane_cnt_d != '0) ? PAD : DRAIN;
                    end
                end
                PAD: begin
                    for (int i = 0; i < P; i++) begin
                        sr_data_d[i*NB +: NB] = (i < int'(lane_cnt_q)) ? build_q[i] : '0;
                    end
                    sr_valid_d = 1'b1;
                    tag_d      = flush_primed_q;
                    lane_cnt_d = '0;
                    state_d    = DRAIN;
                end
                DRAIN: begin
                    sr_data_d   = '0;
                    sr_valid_d  = 1'b1;
                    tag_d       = flush_primed_q;
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                    if (drain_cnt_q == DRAIN_W'(DRAIN_BATCHES - 1)) begin
                        flush_done_d = 1'b1;
                        state_d      = DONE;
                    end
                end
                DONE: begin
                    batch_cnt_d    = '0;
                    lane_cnt_d     = '0;
                    drain_cnt_d    = '0;
                    flush_primed_d = 1'b0;
                    state_d        = FILL;
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q        <= FILL;
            lane_cnt_q     <= '0;
            batch_cnt_q    <= '0;
            drain_cnt_q    <= '0;
            build_q        <= '0;
            sr_data_q      <= '0;
            sr_valid_q     <= 1'b0;
            tag_q          <= 1'b0;
            flush_primed_q <= 1'b0;
            flush_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            lane_cnt_q     <= lane_cnt_d;
            batch_cnt_q    <= batch_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            build_q        <= build_d;
            sr_data_q      <= sr_data_d;
            sr_valid_q     <= sr_valid_d;
            tag_q          <= tag_d;
            flush_primed_q <= flush_primed_d;
            flush_done_q   <= flush_done_d;
        end
    end

    // The tag enters the pipe while the strobe is up, so it lines up with
    // the FIR registers that consume the same batch.
    valid_delay_line #(
        .LATENCY (FIR_LATENCY)
    ) u_tag_pipe (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_valid  (sr_valid_q && tag_q),
        .o_valid  (o_fir_valid)
    );

    assign o_sample_ready = ready;
    assign o_sr_valid     = sr_valid_q;
    assign o_sr_data      = sr_data_q;
    assign o_primed       = (batch_cnt_q == BATCH_W'(PRIME_BATCHES));
    assign o_flush_done   = flush_done_q;

endmodule

// File: tb/tb_fir_batch_sequencer.sv
// Directed bench for the FIR batch sequencer: priming, enable gating, flush,
// simultaneous flush/last-sample and mid-operation reset.
module tb_fir_batch_sequencer;
    import fir_pkg::*;

    logic            clk;
    logic            rst;
    logic            en;
    logic            sv;
    logic [NB-1:0]   smp;
    logic            ready;
    logic            flush;
    logic            sr_valid;
    logic [P*NB-1:0] sr_data;
    logic            primed;
    logic            fir_valid;
    logic            flush_done;

    int n_cmp = 0;
    int n_err = 0;

    fir_batch_sequencer #(
        .FIR_LATENCY (2)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_enable       (en),
        .i_sample_valid (sv),
        .i_sample       (smp),
        .o_sample_ready (ready),
        .i_flush        (flush),
        .o_sr_valid     (sr_valid),
        .o_sr_data      (sr_data),
        .o_primed       (primed),
        .o_fir_valid    (fir_valid),
        .o_flush_done   (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [P*NB-1:0] obs, input logic [P*NB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Batch whose lanes 0..cnt-1 hold first, first+1, ...; remaining lanes zero.
    function automatic logic [P*NB-1:0] mk(input int first, input int cnt);
        logic [P*NB-1:0] b;
        b = '0;
        for (int i = 0; i < cnt; i++) b[i*NB +: NB] = NB'(first + i);
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b1; sv = 1'b0; flush = 1'b0; en = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic prime();
        for (int k = 1; k <= 32; k++) begin
            sv = 1'b1; smp = NB'(k);
            tick();
        end
        sv = 1'b0;
    endtask

    initial begin
        // 1. Reset with random inputs
        rst = 1'b1; en = 1'b1;
        sv = 1'($urandom); flush = 1'($urandom); smp = NB'($urandom);
        #1;
        chk("rst_ready_during", ready, 0);
        tick();
        chk("rst_ready_held", ready, 0);
        chk("rst_sr_valid", sr_valid, 0);
        chk("rst_sr_data", sr_data, 0);
        chk("rst_primed", primed, 0);
        chk("rst_fir_valid", fir_valid, 0);
        chk("rst_flush_done", flush_done, 0);
        rst = 1'b0; sv = 1'b0; flush = 1'b0;
        #1;
        chk("rst_ready_after", ready, 1);
        $display("reset: checked");

        // 2. Priming with samples 1..32
        for (int k = 1; k <= 32; k++) begin
            sv = 1'b1; smp = NB'(k);
            tick();
            chk("prime_sr_valid", sr_valid, (k % 8 == 0));
            if (k % 8 == 0) begin
                chk("prime_sr_data", sr_data, mk(k - 7, 8));
                $display("prime: batch %0d issued", k / 8);
            end
            chk("prime_primed", primed, (k >= 32));
            chk("prime_fir_valid", fir_valid, 0);
        end
        sv = 1'b0;
        tick();
        chk("prime_sr_clear", sr_valid, 0);
        chk("prime_fir_t1", fir_valid, 0);
        tick();
        chk("prime_fir_t2", fir_valid, 1);
        tick();
        chk("prime_fir_t3", fir_valid, 0);

        // 3. Enable gating mid-batch and while the strobe is pending
        for (int k = 40; k <= 42; k++) begin
            sv = 1'b1; smp = NB'(k);
            tick();
        end
        en = 1'b0; smp = NB'(99);
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("gate_ready_low", ready, 0);
            tick();
            chk("gate_no_strobe", sr_valid, 0);
        end
        en = 1'b1;
        for (int k = 43; k <= 47; k++) begin
            smp = NB'(k);
            tick();
            chk("gate_sr_valid", sr_valid, (k == 47));
        end
        chk("gate_sr_data", sr_data, mk(40, 8));
        sv = 1'b0; en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("gate_strobe_held", sr_valid, 1);
            chk("gate_fir_held", fir_valid, 0);
        end
        en = 1'b1;
        tick();
        chk("gate_strobe_consumed", sr_valid, 0);
        chk("gate_fir_t1", fir_valid, 0);
        tick();
        chk("gate_fir_t2", fir_valid, 1);
        tick();
        chk("gate_fir_t3", fir_valid, 0);
        $display("enable gating: batch 40..47 checked");

        // 4. Partial flush after priming
        do_reset();
        prime();
        for (int k = 33; k <= 35; k++) begin
            sv = 1'b1; smp = NB'(k);
            tick();
        end
        sv = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("pflush_ready_pad", ready, 0);
        chk("pflush_no_strobe", sr_valid, 0);
        for (int j = 0; j < 7; j++) begin
            tick();
            chk("pflush_sr_valid", sr_valid, (j < 4));
            if (j == 0) chk("pflush_pad_data", sr_data, mk(33, 3));
            if (j >= 1 && j < 4) chk("pflush_zero_data", sr_data, 0);
            chk("pflush_fir_valid", fir_valid, (j >= 2 && j <= 5));
            chk("pflush_done", flush_done, (j == 3));
            chk("pflush_primed", primed, (j <= 3));
            if (j == 4) chk("pflush_ready_fill", ready, 1);
        end
        for (int k = 50; k <= 57; k++) begin
            sv = 1'b1; smp = NB'(k);
            tick();
        end
        sv = 1'b0;
        chk("pflush_refill_valid", sr_valid, 1);
        chk("pflush_refill_data", sr_data, mk(50, 8));
        chk("pflush_refill_primed", primed, 0);
        tick();
        tick();
        chk("pflush_refill_fir", fir_valid, 0);
        $display("partial flush: pad, 3 drains, done checked");

        // 5. Flush together with the 8th sample, then flush during DRAIN
        do_reset();
        prime();
        for (int k = 60; k <= 66; k++) begin
            sv = 1'b1; smp = NB'(k);
            tick();
        end
        smp = NB'(67); flush = 1'b1;
        tick();
        sv = 1'b0; flush = 1'b0;
        chk("simul_sr_valid", sr_valid, 1);
        chk("simul_sr_data", sr_data, mk(60, 8));
        chk("simul_ready_drain", ready, 0);
        for (int j = 0; j < 5; j++) begin
            flush = (j == 0);
            tick();
            chk("simul_drain_valid", sr_valid, (j < 3));
            if (j < 3) chk("simul_drain_data", sr_data, 0);
            chk("simul_done", flush_done, (j == 2));
            if (j >= 1 && j <= 3) chk("simul_fir_valid", fir_valid, 1);
        end
        flush = 1'b0;
        #1;
        chk("simul_ready_after", ready, 1);
        $display("simultaneous flush: full batch + 3 drains checked");

        // 6. Reset during DRAIN, then reset at lane_cnt=5
        do_reset();
        prime();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("mrst_drain_strobe", sr_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("mrst_sr_valid", sr_valid, 0);
            chk("mrst_fir_valid", fir_valid, 0);
            chk("mrst_done", flush_done, 0);
            chk("mrst_primed", primed, 0);
            tick();
        end
        for (int k = 70; k <= 74; k++) begin
            sv = 1'b1; smp = NB'(k);
            tick();
        end
        sv = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 80; k <= 87; k++) begin
            sv = 1'b1; smp = NB'(k);
            tick();
            chk("mrst_clean_valid", sr_valid, (k == 87));
        end
        sv = 1'b0;
        chk("mrst_clean_data", sr_data, mk(80, 8));
        $display("mid-operation reset: clean batch 80..87 checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
